// File: rtl/insn_sequencer_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer: state encoding,
// latched decode bundle and the default memory-wait limit.
package insn_sequencer_pkg;

  localparam int MEM_WAIT_MAX_DEFAULT = 15;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALTED    = 3'd6,
    FAULT     = 3'd7
  } seq_state_t;

  typedef struct packed {
    logic halt;
    logic branch;
    logic jump;
    logic reg_write;
    logic overflow_write;
    logic compare_write;
    logic memory_read;
    logic memory_write;
  } seq_ctrl_t;

  function automatic logic is_busy(input seq_state_t s);
    return !(s inside {IDLE, HALTED, FAULT});
  endfunction

endpackage

// File: rtl/seq_mem_watchdog.sv
// Memory-wait watchdog: counts MEMORY cycles without ready and flags the cycle
// on which the wait limit is reached.
module seq_mem_watchdog #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic in_mem,
  input  logic mem_ready,
  output logic timeout
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  logic [CW-1:0] wait_reg;
  logic [CW-1:0] wait_next;

  always_comb begin
    wait_next = wait_reg;
    if (clear)
      wait_next = '0;
    else if (in_mem && !mem_ready)
      wait_next = wait_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst)
      wait_reg <= '0;
    else
      wait_reg <= wait_next;
  end

  // Ready in the final allowed cycle still completes; only a miss times out.
  assign timeout = in_mem && !mem_ready && (wait_reg == CW'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/insn_sequencer.sv
// Multi-cycle instruction sequencer gating architectural write strobes.
// Optional performance counters are built when SEQ_PERF_COUNT_EN is defined.
module insn_sequencer
  import insn_sequencer_pkg::*;
#(
  parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEFAULT,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 _clock,
  input  logic                 _reset,
  input  logic                 _start,
  input  logic                 _halt,
  input  logic                 _branch,
  input  logic                 _jump,
  input  logic                 _regWrite,
  input  logic                 _overflowWrite,
  input  logic                 _compareWrite,
  input  logic                 _memoryRead,
  input  logic                 _memoryWrite,
  input  logic                 _memReady,
  output logic                 irLoad,
  output logic                 pcEnable,
  output logic                 branchEn,
  output logic                 jumpEn,
  output logic                 regWriteEn,
  output logic                 overflowWriteEn,
  output logic                 compareWriteEn,
  output logic                 memReadReq,
  output logic                 memWriteReq,
  output logic                 busy,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] cycleCount,
  output logic [CNT_WIDTH-1:0] retiredCount
);

  seq_state_t state_reg;
  seq_ctrl_t  ctrl_reg;
  logic       in_mem;
  logic       in_exec;
  logic       in_wb;
  logic       timeout;

  assign in_mem  = (state_reg == MEMORY);
  assign in_exec = (state_reg == EXECUTE);
  assign in_wb   = (state_reg == WRITEBACK);

  seq_mem_watchdog #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_watchdog (
    .clk      (_clock),
    .srst     (_reset),
    .clear    (state_reg == DECODE),
    .in_mem   (in_mem),
    .mem_ready(_memReady),
    .timeout  (timeout)
  );

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_reg <= IDLE;
      ctrl_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE:      if (_start) state_reg <= FETCH;
        FETCH:     state_reg <= DECODE;
        DECODE: begin
          ctrl_reg <= {_halt, _branch, _jump, _regWrite, _overflowWrite,
                       _compareWrite, _memoryRead, _memoryWrite};
          if (_halt)
            state_reg <= HALTED;
          else if (_memoryRead || _memoryWrite)
            state_reg <= MEMORY;
          else
            state_reg <= EXECUTE;
        end
        EXECUTE:   state_reg <= FETCH;
        MEMORY: begin
          if (_memReady)
            state_reg <= ctrl_reg.memory_read ? WRITEBACK : FETCH;
          else if (timeout)
            state_reg <= FAULT;
        end
        WRITEBACK: state_reg <= FETCH;
        default:   state_reg <= state_reg;
      endcase
    end
  end

  // A read wins when both memory bits were decoded.
  assign irLoad          = (state_reg == FETCH);
  assign pcEnable        = in_exec || in_wb ||
                           (in_mem && _memReady && !ctrl_reg.memory_read);
  assign branchEn        = in_exec && ctrl_reg.branch;
  assign jumpEn          = in_exec && ctrl_reg.jump;
  assign regWriteEn      = (in_exec && ctrl_reg.reg_write) || in_wb;
  assign overflowWriteEn = in_exec && ctrl_reg.overflow_write;
  assign compareWriteEn  = in_exec && ctrl_reg.compare_write;
  assign memReadReq      = in_mem && ctrl_reg.memory_read;
  assign memWriteReq     = in_mem && ctrl_reg.memory_write && !ctrl_reg.memory_read;
  assign busy            = is_busy(state_reg);
  assign halted          = (state_reg == HALTED) && ctrl_reg.halt;
  assign fault           = (state_reg == FAULT);

`ifdef SEQ_PERF_COUNT_EN
  logic [1:0]                cnt_inc;
  logic [1:0][CNT_WIDTH-1:0] cnt_val;

  assign cnt_inc = {pcEnable, busy};

  // Index 0 counts busy cycles, index 1 counts retirements; both saturate.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      always_ff @(posedge _clock) begin
        if (_reset)
          cnt_reg <= '0;
        else if (cnt_inc[gi] && !(&cnt_reg))
          cnt_reg <= cnt_reg + 1'b1;
      end
      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign cycleCount   = cnt_val[0];
  assign retiredCount = cnt_val[1];
`else
  assign cycleCount   = '0;
  assign retiredCount = '0;
`endif

endmodule

// File: tb/tb_insn_sequencer.sv
// Self-checking bench for insn_sequencer: per-cycle expectations come from an
// instruction-level model of the timing rules, plus table and corner sequences.
module tb_insn_sequencer;

  localparam int     WAIT_MAX = 5;
  localparam int     CW       = 16;
  localparam longint MAXC     = (64'd1 << CW) - 1;
  localparam int IR = 11, PC = 10, BR = 9, JP = 8, RW = 7, OW = 6, CE = 5,
                 MR = 4, MW = 3, BZ = 2, HL = 1, FT = 0;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          mrdy  = 1'b0;
  logic [7:0]    ctl   = '0;
  logic          irLoad, pcEnable, branchEn, jumpEn, regWriteEn;
  logic          overflowWriteEn, compareWriteEn, memReadReq, memWriteReq;
  logic          busy, halted, fault;
  logic [CW-1:0] cycleCount, retiredCount;
  logic [11:0]   act;
  int            tests = 0;
  int            fails = 0;
  longint        cyc_m = 0;
  longint        ret_m = 0;

  always #5 clk = ~clk;

  insn_sequencer #(.MEM_WAIT_MAX(WAIT_MAX), .CNT_WIDTH(CW)) dut (
    ._clock(clk), ._reset(rst), ._start(start),
    ._halt(ctl[7]), ._branch(ctl[6]), ._jump(ctl[5]), ._regWrite(ctl[4]),
    ._overflowWrite(ctl[3]), ._compareWrite(ctl[2]),
    ._memoryRead(ctl[1]), ._memoryWrite(ctl[0]), ._memReady(mrdy),
    .irLoad(irLoad), .pcEnable(pcEnable), .branchEn(branchEn), .jumpEn(jumpEn),
    .regWriteEn(regWriteEn), .overflowWriteEn(overflowWriteEn),
    .compareWriteEn(compareWriteEn), .memReadReq(memReadReq),
    .memWriteReq(memWriteReq), .busy(busy), .halted(halted), .fault(fault),
    .cycleCount(cycleCount), .retiredCount(retiredCount)
  );

  assign act = {irLoad, pcEnable, branchEn, jumpEn, regWriteEn, overflowWriteEn,
                compareWriteEn, memReadReq, memWriteReq, busy, halted, fault};

  typedef struct {
    logic [7:0] ctl;
    int         delay;
    int         exp_cycles;
    int         exp_term;
  } vec_t;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [7:0] rc();
    return 8'($urandom);
  endfunction

  // One clock: apply inputs, compare outputs and counters, advance the counter model.
  task automatic cyc(input logic r, input logic st, input logic [7:0] c, input logic rdy,
                     input logic [11:0] e, input string nm);
    logic [CW-1:0] ec, er;
    @(posedge clk); #1;
    rst = r; start = st; ctl = c; mrdy = rdy;
    #1;
`ifdef SEQ_PERF_COUNT_EN
    ec = CW'(cyc_m); er = CW'(ret_m);
`else
    ec = '0; er = '0;
`endif
    tests++;
    if (act !== e || cycleCount !== ec || retiredCount !== er) begin
      fails++;
      $display("FAIL %s: got outs=%b cyc=%0d ret=%0d, expected outs=%b cyc=%0d ret=%0d",
               nm, act, cycleCount, retiredCount, e, ec, er);
    end
    if (r) begin
      cyc_m = 0; ret_m = 0;
    end else begin
      if (e[BZ] && cyc_m < MAXC) cyc_m++;
      if (e[PC] && ret_m < MAXC) ret_m++;
    end
  endtask

  task automatic check_val(input string nm, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; start = rb(); ctl = rc(); mrdy = rb();
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    cyc_m = 0; ret_m = 0;
  endtask

  // Runs one instruction from FETCH entry; term 0 = back in FETCH, 1 = halted, 2 = fault.
  task automatic insn(input logic [7:0] c, input int delay, output int ncyc, output int term);
    logic [11:0] e;
    logic        rd, rdy;
    ncyc = 2; term = 0;
    e = '0; e[IR] = 1'b1; e[BZ] = 1'b1;
    cyc(0, rb(), rc(), rb(), e, "fetch");
    e = '0; e[BZ] = 1'b1;
    cyc(0, rb(), c, rb(), e, "decode");
    if (c[7]) begin
      term = 1;
    end else if (c[1] || c[0]) begin
      rd = c[1];
      for (int k = 0; k < WAIT_MAX; k++) begin
        rdy = (k == delay);
        e = '0; e[BZ] = 1'b1; e[MR] = rd; e[MW] = !rd; e[PC] = !rd && rdy;
        cyc(0, rb(), rc(), rdy, e, rd ? "load_mem" : "store_mem");
        ncyc++;
        if (rdy) break;
      end
      if (delay >= WAIT_MAX) begin
        term = 2;
      end else if (rd) begin
        e = '0; e[BZ] = 1'b1; e[RW] = 1'b1; e[PC] = 1'b1;
        cyc(0, rb(), rc(), rb(), e, "writeback");
        ncyc++;
      end
    end else begin
      e = '0; e[BZ] = 1'b1; e[PC] = 1'b1;
      e[BR] = c[6]; e[JP] = c[5]; e[RW] = c[4]; e[OW] = c[3]; e[CE] = c[2];
      cyc(0, rb(), rc(), rb(), e, "execute");
      ncyc++;
    end
    $display("[TB] insn ctl=%b delay=%0d cycles=%0d end=%0d", c, delay, ncyc, term);
  endtask

  task automatic absorb(input int term, input int n);
    logic [11:0] e;
    e = '0;
    if (term == 1) e[HL] = 1'b1;
    else           e[FT] = 1'b1;
    for (int i = 0; i < n; i++)
      cyc(0, (i == 0) ? 1'b1 : rb(), rc(), rb(), e, (term == 1) ? "halted_hold" : "fault_hold");
  endtask

  initial begin
    vec_t        tbl[10];
    logic [11:0] e;
    logic [7:0]  c;
    int          n, t, d, nins;

    tbl[0] = '{8'b0001_0000, 0, 3, 0};          // ALU with regWrite
    tbl[1] = '{8'b0000_0100, 0, 3, 0};          // compare
    tbl[2] = '{8'b0100_1000, 0, 3, 0};          // branch + overflow write
    tbl[3] = '{8'b0010_0000, 0, 3, 0};          // jump
    tbl[4] = '{8'b0000_0010, 4, 8, 0};          // load, ready after 4
    tbl[5] = '{8'b0000_0001, 0, 3, 0};          // store, immediate ready
    tbl[6] = '{8'b0001_0011, 2, 6, 0};          // both memory bits: treated as load
    tbl[7] = '{8'b0000_0001, WAIT_MAX - 1, 3 + WAIT_MAX - 1, 0};
    tbl[8] = '{8'b0000_0010, WAIT_MAX - 1, 4 + WAIT_MAX - 1, 0};
    tbl[9] = '{8'b0111_1101, 1, 4, 0};          // store ignores latched ALU strobes

    do_reset();
    cyc(0, 0, rc(), rb(), '0, "reset_idle");
    cyc(0, 0, rc(), rb(), '0, "idle_hold");
    cyc(0, 1, rc(), rb(), '0, "idle_start");
    for (int i = 0; i < 10; i++) begin
      insn(tbl[i].ctl, tbl[i].delay, n, t);
      check_val($sformatf("table%0d_cycles", i), n, tbl[i].exp_cycles);
      check_val($sformatf("table%0d_end", i), t, tbl[i].exp_term);
    end
    insn(8'hFF, 0, n, t);
    check_val("halt_priority_end", t, 1);
    absorb(1, 3);

    // Two ALU ops then halt.
    do_reset();
    cyc(0, 1, rc(), rb(), '0, "h_start");
    insn(8'b0001_0000, 0, n, t);
    insn(8'b0001_0100, 0, n, t);
    insn(8'b1000_0000, 0, n, t);
    absorb(1, 1);
`ifdef SEQ_PERF_COUNT_EN
    check_val("halt_cycle_count", cycleCount, 8);
    check_val("halt_retired_count", retiredCount, 2);
`else
    check_val("halt_cycle_count", cycleCount, 0);
    check_val("halt_retired_count", retiredCount, 0);
`endif

    // Load that never sees ready.
    do_reset();
    cyc(0, 1, rc(), rb(), '0, "f_start");
    insn(8'b0000_0010, 100, n, t);
    check_val("fault_cycles", n, 2 + WAIT_MAX);
    check_val("fault_end", t, 2);
    absorb(2, 4);
    do_reset();
    cyc(0, 0, rc(), rb(), '0, "after_fault_reset");

    // Reset in the second MEMORY cycle of a load, with start and ready also high.
    do_reset();
    cyc(0, 1, rc(), rb(), '0, "r_start");
    e = '0; e[IR] = 1'b1; e[BZ] = 1'b1;
    cyc(0, 0, rc(), 0, e, "r_fetch");
    e = '0; e[BZ] = 1'b1;
    cyc(0, 0, 8'b0001_0010, 0, e, "r_decode");
    e = '0; e[BZ] = 1'b1; e[MR] = 1'b1;
    cyc(0, 0, rc(), 0, e, "r_mem1");
    cyc(1, 1, rc(), 1, e, "r_mem2_reset");
    cyc(0, 0, rc(), rb(), '0, "r_idle");
    cyc(0, 0, rc(), rb(), '0, "r_idle2");

    // Random instruction streams, each ending in halt or fault.
    for (int b = 0; b < 25; b++) begin
      do_reset();
      cyc(0, 1, rc(), rb(), '0, "rnd_start");
      nins = $urandom_range(1, 6);
      t = 0;
      for (int j = 0; j < nins && t == 0; j++) begin
        c = rc(); c[7] = 1'b0;
        d = ($urandom_range(0, 7) == 0) ? WAIT_MAX + int'($urandom_range(0, 3))
                                        : int'($urandom_range(0, WAIT_MAX - 1));
        insn(c, d, n, t);
      end
      if (t == 0) begin
        c = rc(); c[7] = 1'b1;
        insn(c, 0, n, t);
      end
      absorb(t, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/insn_sequencer.md
# insn_sequencer

Multi-cycle instruction sequencer for the single-issue core. It sits between instruction fetch, the combinational control unit, the register file, the ALU flags and data memory. It steps each instruction through fetch, decode, execute and memory/writeback, and gates every architectural write strobe so that each strobe fires exactly once per instruction. It also owns the data-memory request/ready handshake, halt and fault handling, and optional performance counters.

## Interface
Parameters:
- MEM_WAIT_MAX, 15: maximum cycles a memory request may wait for ready before a fault is raised; must be ≥1.
- CNT_WIDTH, 16: width of the performance counters.

Ports:
- _clock  in  1  core clock; all state changes on the rising edge.
- _reset  in  1  synchronous, active-high reset.
- _start  in  1  one-cycle pulse that begins execution from IDLE.
- _halt, _branch, _jump, _regWrite, _overflowWrite, _compareWrite, _memoryRead, _memoryWrite  in  1 each  decoded control from the control unit, valid during DECODE.
- _memReady  in  1  data-memory completion.
- irLoad  out  1  latch the ROM word into the instruction register.
- pcEnable  out  1  advance or redirect the PC.
- branchEn, jumpEn  out  1 each  the redirect qualifiers for pcEnable.
- regWriteEn, overflowWriteEn, compareWriteEn  out  1 each  gated write strobes.
- memReadReq, memWriteReq  out  1 each  data-memory request.
- busy  out  1  high when the state is not IDLE, HALTED or FAULT.
- halted  out  1  high in HALTED.
- fault  out  1  high in FAULT.
- cycleCount, retiredCount  out  CNT_WIDTH each  performance counters.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALTED, FAULT.
- Reset:
  - state goes to IDLE.
  - Latched control, wait counter and performance counters clear.
  - Every output is 0.
- IDLE: on _start go to FETCH; otherwise hold. _start is ignored in all other states.
- FETCH: irLoad=1; go to DECODE.
- DECODE: latch all eight control inputs. Then:
  - _halt: go to HALTED; no other strobe fires.
  - else _memoryRead or _memoryWrite: go to MEMORY, wait counter = 0.
  - else: go to EXECUTE.
  - If both memory inputs are high, treat the instruction as a read.
- EXECUTE:
  - pcEnable=1.
  - branchEn and jumpEn take the latched _branch and _jump.
  - regWriteEn, overflowWriteEn and compareWriteEn take their latched inputs.
  - Go to FETCH.
- MEMORY:
  - memReadReq or memWriteReq is held high for as long as the state stays MEMORY.
  - If _memReady=1: a read goes to WRITEBACK; a write sets pcEnable=1 in the same cycle and goes to FETCH.
  - Else the wait counter increments. When it reaches MEM_WAIT_MAX, go to FAULT.
- WRITEBACK: regWriteEn=1, pcEnable=1; go to FETCH.
- HALTED and FAULT are absorbing; only _reset leaves them.
- _memReady outside MEMORY is ignored.
- All outputs are Moore decodes of the state and latched registers. None depends combinationally on any input except the same-cycle pcEnable on a write completion in MEMORY.

## Timing
- ALU, compare and branch instructions: 3 cycles (FETCH, DECODE, EXECUTE).
- Load: 4+w cycles, where w is the number of MEMORY cycles before ready (w=0 when ready arrives in the first MEMORY cycle).
- Store: 3+w cycles.
- Halt: 2 cycles after FETCH entry the machine is in HALTED, and halted=1 from the following cycle on.
- Fault: on the MEM_WAIT_MAX-th MEMORY cycle without ready, the state goes to FAULT. fault=1 from the next cycle and the request drops at the same time.
- Reset in any state, including MEMORY with a request outstanding: the next cycle is IDLE with all outputs 0. Any write not yet strobed is discarded.
- _reset takes priority over _start in the same cycle.

## Configuration
- SEQ_PERF_COUNT_EN defined:
  - cycleCount increments every cycle while busy=1.
  - retiredCount increments each cycle pcEnable=1; an instruction that enters HALTED is not counted.
  - Both counters saturate at all-ones and clear only on reset.
- SEQ_PERF_COUNT_EN not defined: both counters are tied to 0 and no counter registers exist.

## Structure
- Shared definitions package holds:
  - the sequencer state enum (3-bit, explicit encodings: IDLE=0 through FAULT=7);
  - the default MEM_WAIT_MAX constant.
- One sub-module, seq_mem_watchdog: the wait counter, its clear and increment, and the timeout flag. It takes the in-MEMORY qualifier and _memReady.

## Test plan
- Reset, _start, then an ALU op (no memory) → irLoad in cycle 1, EXECUTE in cycle 3 with regWriteEn=1 and pcEnable=1, then FETCH again. retiredCount=1 with the macro defined.
- Load with _memReady delayed 4 cycles → memReadReq high for 5 cycles, regWriteEn only in WRITEBACK, total 8 cycles.
- Store with _memReady in the first MEMORY cycle → memWriteReq for 1 cycle, pcEnable in that same cycle, regWriteEn never asserted.
- MEM_WAIT_MAX=3 and _memReady never asserted → fault=1 after 3 MEMORY cycles and held; a later _start has no effect; _reset returns to IDLE.
- Halt after 2 ALU ops → halted=1 and busy=0. With the macro: retiredCount=2, cycleCount=8 (3+3+2).
- _reset asserted in the 2nd MEMORY cycle of a load → next cycle IDLE, memReadReq=0, no regWriteEn, counters at 0.
